// File: rtl/riscv_muldiv_arbiter.sv
// Two-port round-robin front end for a shared iterative RISC-V M-extension unit.
// Zero-operand ops and exact repeats of the last unit op are answered without starting the unit.
module riscv_muldiv_arbiter #(
   parameter bit ZERO_BYPASS = 1'b1,
   parameter bit CACHE_EN    = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [2:0]  req0_funct3,
   input  logic [31:0] req0_s1,
   input  logic [31:0] req0_s2,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [2:0]  req1_funct3,
   input  logic [31:0] req1_s1,
   input  logic [31:0] req1_s2,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_data,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_data,
   output logic        mu_start,
   output logic [2:0]  mu_funct3,
   output logic [31:0] mu_s1,
   output logic [31:0] mu_s2,
   input  logic        mu_done,
   input  logic [31:0] mu_result
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

   state_e      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_grant_q, last_grant_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] s1_q, s1_d;
   logic [31:0] s2_q, s2_d;
   logic [31:0] data_q, data_d;
   logic        cache_valid_q, cache_valid_d;
   logic [2:0]  cache_funct3_q, cache_funct3_d;
   logic [31:0] cache_s1_q, cache_s1_d;
   logic [31:0] cache_s2_q, cache_s2_d;
   logic [31:0] cache_result_q, cache_result_d;

   logic        req_any;
   logic        grant_sel;
   logic [2:0]  sel_funct3;
   logic [31:0] sel_s1;
   logic [31:0] sel_s2;
   logic [31:0] zero_result;
   logic        zero_hit;
   logic        cache_hit;

   // On a tie the requester that did not win last time goes first.
   always_comb begin : grant_select
      req_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant_sel = ~last_grant_q;
      end else begin
         grant_sel = req1_valid;
      end
      sel_funct3 = grant_sel ? req1_funct3 : req0_funct3;
      sel_s1     = grant_sel ? req1_s1     : req0_s1;
      sel_s2     = grant_sel ? req1_s2     : req0_s2;
   end

   always_comb begin : bypass_eval
      zero_result = '0;
      if (sel_s2 == '0) begin
         if (!sel_funct3[2]) begin
            zero_result = '0;
         end else if (!sel_funct3[1]) begin
            zero_result = '1;
         end else begin
            zero_result = sel_s1;
         end
      end
      zero_hit  = ZERO_BYPASS && ((sel_s1 == '0) || (sel_s2 == '0));
      cache_hit = CACHE_EN && cache_valid_q &&
                  (cache_funct3_q == sel_funct3) &&
                  (cache_s1_q == sel_s1) && (cache_s2_q == sel_s2);
   end

   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               state_d = (zero_hit || cache_hit) ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (mu_done) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin : datapath_next
      owner_d        = owner_q;
      last_grant_d   = last_grant_q;
      funct3_d       = funct3_q;
      s1_d           = s1_q;
      s2_d           = s2_q;
      data_d         = data_q;
      cache_valid_d  = cache_valid_q;
      cache_funct3_d = cache_funct3_q;
      cache_s1_d     = cache_s1_q;
      cache_s2_d     = cache_s2_q;
      cache_result_d = cache_result_q;
      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               owner_d  = grant_sel;
               funct3_d = sel_funct3;
               s1_d     = sel_s1;
               s2_d     = sel_s2;
               // Zero bypass outranks the cache when both would answer.
               data_d   = zero_hit ? zero_result : cache_result_q;
            end
         end
         ST_WAIT: begin
            if (mu_done) begin
               data_d         = mu_result;
               cache_valid_d  = CACHE_EN;
               cache_funct3_d = funct3_q;
               cache_s1_d     = s1_q;
               cache_s2_d     = s2_q;
               cache_result_d = mu_result;
            end
         end
         ST_RESP: last_grant_d = owner_q;
         default: ;
      endcase
   end

   // Outputs are forced low while reset is high so an abandoned op never strobes.
   always_comb begin : outputs
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      rsp0_data  = '0;
      rsp1_data  = '0;
      mu_start   = 1'b0;
      mu_funct3  = '0;
      mu_s1      = '0;
      mu_s2      = '0;
      if (!reset) begin
         case (state_q)
            ST_IDLE: begin
               req0_ready = req_any && !grant_sel;
               req1_ready = req_any && grant_sel;
            end
            ST_ISSUE: begin
               mu_start  = 1'b1;
               mu_funct3 = funct3_q;
               mu_s1     = s1_q;
               mu_s2     = s2_q;
            end
            ST_RESP: begin
               rsp0_valid = !owner_q;
               rsp1_valid = owner_q;
               rsp0_data  = owner_q ? '0 : data_q;
               rsp1_data  = owner_q ? data_q : '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin : state_reg
      if (reset) begin
         state_q        <= ST_IDLE;
         owner_q        <= 1'b0;
         last_grant_q   <= 1'b1;
         funct3_q       <= '0;
         s1_q           <= '0;
         s2_q           <= '0;
         data_q         <= '0;
         cache_valid_q  <= 1'b0;
         cache_funct3_q <= '0;
         cache_s1_q     <= '0;
         cache_s2_q     <= '0;
         cache_result_q <= '0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         last_grant_q   <= last_grant_d;
         funct3_q       <= funct3_d;
         s1_q           <= s1_d;
         s2_q           <= s2_d;
         data_q         <= data_d;
         cache_valid_q  <= cache_valid_d;
         cache_funct3_q <= cache_funct3_d;
         cache_s1_q     <= cache_s1_d;
         cache_s2_q     <= cache_s2_d;
         cache_result_q <= cache_result_d;
      end
   end

endmodule
